// File: rtl/jt900h_shift.sv
// jt900h_shift: multi-cycle shift/rotate engine for the TLCS-900H execute stage.
// Performs RLC/RRC/RL/RR/SLA/SRA/SLL/SRL on byte, word or long operands,
// one bit per enabled clock, for a count of 1..16 (cnt=0 means 16).
//
// Ports:
//   clk, rst (async, active-low), cen (clock enable)
//   start, mode[2:0], bs, ws, cnt[3:0], din[31:0], cin   - request and operands
//   busy (combinational from state), done (registered one-cen-cycle pulse)
//   dout[31:0], c, z, n, p                                - registered result and flags
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; result and flags hold the last result
// SHIFT  | one 1-bit step per cen cycle until the count is exhausted
// DONE   | done asserted for one cen cycle; start is ignored here

module jt900h_shift (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        start,
    input  logic [2:0]  mode,
    input  logic        bs,
    input  logic        ws,
    input  logic [3:0]  cnt,
    input  logic [31:0] din,
    input  logic        cin,
    output logic        busy,
    output logic        done,
    output logic [31:0] dout,
    output logic        c,
    output logic        z,
    output logic        n,
    output logic        p
);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
    typedef enum logic [1:0] {W_BYTE, W_WORD, W_LONG} width_t;

    localparam logic [2:0] M_RLC = 3'd0;
    localparam logic [2:0] M_RRC = 3'd1;
    localparam logic [2:0] M_RL  = 3'd2;
    localparam logic [2:0] M_RR  = 3'd3;
    localparam logic [2:0] M_SRA = 3'd5;

    state_t      state_q, state_d;
    width_t      width_q, width_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  mode_q, mode_d;
    logic [31:0] work_q, work_d;
    logic        carry_q, carry_d;
    logic        done_q, done_d;
    logic [31:0] dout_q, dout_d;
    logic        c_q, c_d;
    logic        z_q, z_d;
    logic        n_q, n_d;
    logic        p_q, p_d;

    // Active-width mask and MSB selector
    logic [31:0] mask;
    logic [31:0] top;

    always_comb begin
        mask = 32'hFFFF_FFFF;
        top  = 32'h8000_0000;
        case (width_q)
            W_BYTE: begin
                mask = 32'h0000_00FF;
                top  = 32'h0000_0080;
            end
            W_WORD: begin
                mask = 32'h0000_FFFF;
                top  = 32'h0000_8000;
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                top  = 32'h8000_0000;
            end
        endcase
    end

    // One-bit step. Even modes shift left, odd modes shift right; fill is the
    // bit entering at bit0 (left) or at bit w (right).
    logic [31:0] act;
    logic [31:0] step_act;
    logic [31:0] step;
    logic        msb;
    logic        lsb;
    logic        fill;
    logic        step_carry;
    logic [31:0] res_act;

    always_comb begin
        act  = work_q & mask;
        msb  = |(work_q & top);
        lsb  = work_q[0];
        fill = 1'b0;
        case (mode_q)
            M_RLC:   fill = msb;
            M_RRC:   fill = lsb;
            M_RL:    fill = carry_q;
            M_RR:    fill = carry_q;
            M_SRA:   fill = msb;
            default: fill = 1'b0;
        endcase
        if (!mode_q[0]) begin
            step_act   = ((act << 1) | {31'b0, fill}) & mask;
            step_carry = msb;
        end else begin
            step_act   = (act >> 1) | (fill ? top : 32'b0);
            step_carry = lsb;
        end
        // Bits above the active width pass through untouched
        step    = (work_q & ~mask) | step_act;
        res_act = step & mask;
    end

    always_comb begin
        state_d = state_q;
        width_d = width_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        work_d  = work_q;
        carry_d = carry_q;
        done_d  = done_q;
        dout_d  = dout_q;
        c_d     = c_q;
        z_d     = z_q;
        n_d     = n_q;
        p_d     = p_q;
        if (cen) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_SHIFT;
                        work_d  = din;
                        cnt_d   = (cnt == 4'd0) ? 5'd16 : {1'b0, cnt};
                        mode_d  = mode;
                        width_d = bs ? W_BYTE : (ws ? W_WORD : W_LONG);
                        carry_d = cin;
                    end
                end
                ST_SHIFT: begin
                    work_d  = step;
                    carry_d = step_carry;
                    cnt_d   = cnt_q - 5'd1;
                    // Last step: publish the result straight from the step logic
                    if (cnt_q == 5'd1) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        dout_d  = step;
                        c_d     = step_carry;
                        z_d     = (res_act == 32'b0);
                        n_d     = |(step & top);
                        p_d     = ~^res_act;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            width_q <= W_BYTE;
            cnt_q   <= 5'd0;
            mode_q  <= 3'd0;
            work_q  <= 32'b0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= 32'b0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            p_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            width_q <= width_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            work_q  <= work_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            c_q     <= c_d;
            z_q     <= z_d;
            n_q     <= n_d;
            p_q     <= p_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign dout = dout_q;
    assign c    = c_q;
    assign z    = z_q;
    assign n    = n_q;
    assign p    = p_q;

endmodule

// File: doc/jt900h_shift.md
# jt900h_shift

Multi-cycle shift/rotate engine for the TLCS-900H core, sitting in the execute stage beside the ALU. It serves the RLC/RRC/RL/RR/SLA/SRA/SLL/SRL instructions at byte, word and long widths, with a shift count of 1–16. It shifts one bit per enabled clock, so a long count costs cycles but no barrel-shifter area. The final result and flags go to the same writeback path as ALU results.

## Interface
Parameters: none.

- `clk` in 1 — system clock.
- `rst` in 1 — reset. One clock; reset is asynchronous and active-low.
- `cen` in 1 — clock enable. All state advances only when `cen`=1.
- `start` in 1 — request a shift. Sampled on a `cen` cycle.
- `mode` in 3 — operation: 0 RLC, 1 RRC, 2 RL, 3 RR, 4 SLA, 5 SRA, 6 SLL, 7 SRL.
- `bs` in 1 — byte width.
- `ws` in 1 — word width. Long width when both `bs` and `ws` are 0; `bs` has priority.
- `cnt` in 4 — shift count. Value 0 means 16.
- `din` in 32 — operand.
- `cin` in 1 — carry flag in. Used by RL and RR.
- `busy` out 1 — operation in progress.
- `done` out 1 — one-`cen`-cycle pulse when `dout` and the flags are valid.
- `dout` out 32 — result.
- `c` out 1 — carry flag.
- `z` out 1 — zero flag.
- `n` out 1 — sign flag.
- `p` out 1 — parity flag.

## Operation
- **States:**
  - IDLE → SHIFT on a `cen` cycle with `start`=1.
  - SHIFT → DONE when the remaining count reaches 0 on a `cen` cycle.
  - DONE → IDLE on the next `cen` cycle.
- **Capture (IDLE + `start` + `cen`):** latch `din` into the working register, the count (0 → 16), `mode`, the width, and `cin` into the carry register.
- **SHIFT:** each `cen` cycle performs exactly one 1-bit step on the active width. Let w be the MSB index (7, 15 or 31).
  - RLC: bit0 ← bit w; carry ← bit w.
  - RRC: bit w ← bit0; carry ← bit0.
  - RL: bit0 ← carry; carry ← bit w.
  - RR: bit w ← carry; carry ← bit0.
  - SLA and SLL: bit0 ← 0; carry ← bit w.
  - SRA: bit w is kept; carry ← bit0.
  - SRL: bit w ← 0; carry ← bit0.
- **Upper bits:** bits above the active width pass through from the captured `din`, unchanged.
- **Flags (DONE):**
  - `c` is the last bit shifted out.
  - `z`=1 when all active-width bits are 0.
  - `n` is bit w.
  - `p`=1 for even parity over the active width.
- **Output hold:** `dout` and the flags are held stable from DONE until the next capture.
- **`start` while busy:** ignored, no queueing.
- **`start` in DONE:** ignored; it is accepted from IDLE on a later cycle.
- **Width/mode changes mid-operation:** `bs`, `ws` and `mode` are ignored after capture.
- **Reset (asserted at any time, including mid-SHIFT):**
  - State → IDLE.
  - `busy`=0, `done`=0.
  - `dout`=0.
  - `c`, `z`, `n`, `p` = 0.
  - Count and working registers cleared.
  - No `done` is produced for the aborted operation.

## Timing
- `busy`=1 in SHIFT and DONE, combinationally from state; 0 in IDLE.
- Latency for count N (1..16): capture on `cen` edge 0, shift steps on `cen` edges 1..N.
  - `done`=1 during the following `cen` cycle (edge N+1).
  - Next `start` is accepted on edge N+2 at earliest.
- `cen`=0 freezes the state, counter, working register and `done`.
  - `done` stays high across non-`cen` clocks until the next `cen` edge retires it.
- `done` and `dout` are registered; no combinational path from inputs to outputs except `busy`.

## Test plan
- Byte RLC, `din`=0x00000085, `cnt`=1 → `dout`=0x0000000B, `c`=1, `n`=0, `z`=0, `p`=0; `done` on the 2nd `cen` edge after start.
- Word SRA, `din`=0x00008001, `cnt`=4 → `dout`=0x0000F800, `c`=0, `n`=1, `z`=0; `busy` high for exactly 5 `cen` cycles.
- Long RR, `cin`=1, `din`=0x00000001, `cnt`=1 → `dout`=0x80000000, `c`=1, `n`=1.
- Word SLL, `din`=0x00000001, `cnt`=0 (16 steps) → `dout`=0x00000000, `c`=1, `z`=1, `p`=1. Repeat with `cen` toggling every other clock; the same result arrives after 17 `cen` edges.
- Byte SRL, `din`=0x12345680, `cnt`=7 → `dout`=0x12345601, `c`=0. Pulse `start` with different data while busy; the result must be unchanged.
- Assert `rst` low mid-SHIFT → `busy`, `done`, `dout` and all flags = 0 immediately. After release, a fresh byte RL with `cin`=1, `din`=0x7F, `cnt`=1 → `dout`=0x000000FF, `c`=0, `n`=1.
